// File: rtl/control_ws_if.sv
// Sequencer bus: IR/flag/memory-handshake inputs and datapath/memory strobes.
// The slave modport is the sequencer side; master is the surrounding datapath.
interface control_ws_if #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_rdy;
    logic                resume;
    logic                mem_rd;
    logic                load_ir;
    logic                halt;
    logic                inc_pc;
    logic                load_ac;
    logic                load_pc;
    logic                mem_wr;
    logic                bus_err;
    logic                instr_done;
    logic [CNT_W-1:0]    retired_cnt;

    modport slave (
        input  opcode, zero, mem_rdy, resume,
        output mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr,
               bus_err, instr_done, retired_cnt
    );

    modport master (
        output opcode, zero, mem_rdy, resume,
        input  mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr,
               bus_err, instr_done, retired_cnt
    );
endinterface

// File: rtl/control_ws.sv
// Eight-phase accumulator-core sequencer with memory wait states, bus-timeout
// trap and a resumable halt state that counts retired instructions.
module control_ws #(
    parameter int unsigned OPCODE_W    = 3,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst_,
    control_ws_if.slave   bus
);
    localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYC != 0);

    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

    typedef enum logic [3:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR,
        OP_FETCH, ALU_OP, STORE, HALTED, BUS_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retired_q;
    logic              bus_err_q;

    logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;
    logic stall, timeout, retire;

    always_comb begin
        is_hlt   = (bus.opcode == OP_HLT);
        is_skz   = (bus.opcode == OP_SKZ);
        is_sto   = (bus.opcode == OP_STO);
        is_jmp   = (bus.opcode == OP_JMP);
        is_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    end

    // Stall only where a memory access is actually in flight.
    always_comb begin
        stall = 1'b0;
        case (state)
            INST_FETCH: stall = !bus.mem_rdy;
            OP_FETCH:   stall = is_aluop && !bus.mem_rdy;
            STORE:      stall = is_sto && !bus.mem_rdy;
            default:    stall = 1'b0;
        endcase
        timeout = TIMEOUT_EN && stall && (wait_cnt == WAIT_LAST);
    end

    // Next state, retirement and Moore-plus-opcode strobe decode.
    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.load_ir = 1'b0;
        bus.halt    = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.load_ac = 1'b0;
        bus.load_pc = 1'b0;
        bus.mem_wr  = 1'b0;
        case (state)
            INST_ADDR: state_nxt = INST_FETCH;
            INST_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_rdy) state_nxt = INST_LOAD;
            end
            INST_LOAD: begin
                bus.mem_rd  = 1'b1;
                bus.load_ir = 1'b1;
                state_nxt   = IDLE;
            end
            IDLE: begin
                bus.mem_rd  = 1'b1;
                bus.load_ir = 1'b1;
                state_nxt   = OP_ADDR;
            end
            OP_ADDR: begin
                bus.inc_pc = 1'b1;
                bus.halt   = is_hlt;
                retire     = is_hlt;
                state_nxt  = is_hlt ? HALTED : OP_FETCH;
            end
            OP_FETCH: begin
                bus.mem_rd = is_aluop;
                if (!is_aluop || bus.mem_rdy) state_nxt = ALU_OP;
            end
            ALU_OP: begin
                bus.mem_rd  = is_aluop;
                bus.load_ac = is_aluop;
                bus.inc_pc  = is_skz && bus.zero;
                bus.load_pc = is_jmp;
                state_nxt   = STORE;
            end
            STORE: begin
                bus.mem_rd  = is_aluop;
                bus.load_ac = is_aluop;
                bus.inc_pc  = is_jmp;
                bus.load_pc = is_jmp;
                bus.mem_wr  = is_sto;
                if (!is_sto || bus.mem_rdy) begin
                    retire    = 1'b1;
                    state_nxt = INST_ADDR;
                end
            end
            HALTED: begin
                bus.halt = 1'b1;
                if (bus.resume) state_nxt = INST_ADDR;
            end
            BUS_ERR: state_nxt = BUS_ERR;
            default: state_nxt = INST_ADDR;
        endcase
        if (timeout) state_nxt = BUS_ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= INST_ADDR;
            wait_cnt  <= '0;
            retired_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= stall ? wait_cnt + WAIT_W'(1) : '0;
            if (retire)  retired_q <= retired_q + CNT_W'(1);
            if (timeout) bus_err_q <= 1'b1;
        end
    end

    assign bus.instr_done  = retire;
    assign bus.retired_cnt = retired_q;
    assign bus.bus_err     = bus_err_q;
endmodule

// File: tb/tb_control_ws.sv
// Directed bench: two sequencers (default, and TIMEOUT_CYC=4 / CNT_W=2) share
// one stimulus stream; expected strobe patterns are hand-derived per phase.
module tb_control_ws;
    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5,
                           STO = 3'd6, JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero, mem_rdy, resume;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    control_ws_if #(.OPCODE_W(3), .CNT_W(16)) ia ();
    control_ws_if #(.OPCODE_W(3), .CNT_W(2))  ib ();

    assign ia.opcode = opcode;  assign ib.opcode = opcode;
    assign ia.zero = zero;      assign ib.zero = zero;
    assign ia.mem_rdy = mem_rdy; assign ib.mem_rdy = mem_rdy;
    assign ia.resume = resume;  assign ib.resume = resume;

    control_ws #(.OPCODE_W(3), .TIMEOUT_CYC(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst_(rst_), .bus(ia));
    control_ws #(.OPCODE_W(3), .TIMEOUT_CYC(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_(rst_), .bus(ib));

    // strobe order: mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr
    logic [6:0] sa, sb;
    assign sa = {ia.mem_rd, ia.load_ir, ia.halt, ia.inc_pc, ia.load_ac, ia.load_pc, ia.mem_wr};
    assign sb = {ib.mem_rd, ib.load_ir, ib.halt, ib.inc_pc, ib.load_ac, ib.load_pc, ib.mem_wr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the current phase on both DUTs, then advance one clock.
    task automatic cyc(input logic [6:0] exp, input logic done, input string tag);
        #1;
        chk({tag, "_strb_a"}, 32'(sa), 32'(exp));
        chk({tag, "_strb_b"}, 32'(sb), 32'(exp));
        chk({tag, "_done_a"}, 32'(ia.instr_done), 32'(done));
        chk({tag, "_done_b"}, 32'(ib.instr_done), 32'(done));
        step();
    endtask

    task automatic fetch_phase(input logic [2:0] op);
        opcode  = op;
        mem_rdy = 1'b1;
        cyc(7'b0000000, 1'b0, "iaddr");
        cyc(7'b1000000, 1'b0, "ifetch");
        cyc(7'b1100000, 1'b0, "iload");
        cyc(7'b1100000, 1'b0, "idle");
    endtask

    initial begin
        rst_ = 1'b0; opcode = ADD; zero = 1'b0; mem_rdy = 1'b1; resume = 1'b0;
        step(); step();
        #1;
        chk("rst_strb", 32'(sa), 32'd0);
        chk("rst_cnt_a", 32'(ia.retired_cnt), 32'd0);
        chk("rst_cnt_b", 32'(ib.retired_cnt), 32'd0);
        chk("rst_err_a", 32'(ia.bus_err), 32'd0);
        rst_ = 1'b1;

        // ADD with no wait states: 8 phases
        fetch_phase(ADD);
        cyc(7'b0001000, 1'b0, "add_opaddr");
        cyc(7'b1000000, 1'b0, "add_opfetch");
        cyc(7'b1000100, 1'b0, "add_alu");
        cyc(7'b1000100, 1'b1, "add_store");
        chk("add_cnt_a", 32'(ia.retired_cnt), 32'd1);
        chk("add_cnt_b", 32'(ib.retired_cnt), 32'd1);

        // LDA with 3 wait cycles in OP_FETCH: 11 phases
        fetch_phase(LDA);
        cyc(7'b0001000, 1'b0, "lda_opaddr");
        mem_rdy = 1'b0;
        cyc(7'b1000000, 1'b0, "lda_wait0");
        cyc(7'b1000000, 1'b0, "lda_wait1");
        cyc(7'b1000000, 1'b0, "lda_wait2");
        mem_rdy = 1'b1;
        cyc(7'b1000000, 1'b0, "lda_opfetch");
        cyc(7'b1000100, 1'b0, "lda_alu");
        cyc(7'b1000100, 1'b1, "lda_store");
        chk("lda_cnt_a", 32'(ia.retired_cnt), 32'd2);
        chk("lda_err_a", 32'(ia.bus_err), 32'd0);
        chk("lda_err_b", 32'(ib.bus_err), 32'd0);

        // Bus timeout: dut_b traps after 4 stalled INST_FETCH cycles
        opcode = ADD; mem_rdy = 1'b0;
        cyc(7'b0000000, 1'b0, "to_iaddr");
        for (int i = 0; i < 4; i++) cyc(7'b1000000, 1'b0, "to_ifetch");
        #1;
        chk("to_strb_b", 32'(sb), 32'd0);
        chk("to_err_b", 32'(ib.bus_err), 32'd1);
        chk("to_strb_a", 32'(sa), 32'(7'b1000000));
        chk("to_err_a", 32'(ia.bus_err), 32'd0);
        mem_rdy = 1'b1;
        step(); step(); #1;
        chk("to_sticky_strb_b", 32'(sb), 32'd0);
        chk("to_sticky_err_b", 32'(ib.bus_err), 32'd1);
        rst_ = 1'b0;
        step(); #1;
        chk("to_rst_err_b", 32'(ib.bus_err), 32'd0);
        chk("to_rst_strb_b", 32'(sb), 32'd0);
        chk("to_rst_cnt_a", 32'(ia.retired_cnt), 32'd0);
        rst_ = 1'b1;

        // HLT: resume during OP_ADDR must not skip HALTED
        fetch_phase(HLT);
        resume = 1'b1;
        cyc(7'b0011000, 1'b1, "hlt_opaddr");
        resume = 1'b0;
        for (int i = 0; i < 5; i++) cyc(7'b0010000, 1'b0, "hlt_halted");
        chk("hlt_cnt_a", 32'(ia.retired_cnt), 32'd1);
        resume = 1'b1;
        cyc(7'b0010000, 1'b0, "hlt_resume");
        resume = 1'b0;

        // SKZ zero=1 / zero=0, then JMP (OP_FETCH ignores mem_rdy for non-ALU ops)
        zero = 1'b1;
        fetch_phase(SKZ);
        cyc(7'b0001000, 1'b0, "skz1_opaddr");
        mem_rdy = 1'b0;
        cyc(7'b0000000, 1'b0, "skz1_opfetch");
        cyc(7'b0001000, 1'b0, "skz1_alu");
        cyc(7'b0000000, 1'b1, "skz1_store");
        zero = 1'b0;
        fetch_phase(SKZ);
        cyc(7'b0001000, 1'b0, "skz0_opaddr");
        cyc(7'b0000000, 1'b0, "skz0_opfetch");
        cyc(7'b0000000, 1'b0, "skz0_alu");
        cyc(7'b0000000, 1'b1, "skz0_store");
        fetch_phase(JMP);
        cyc(7'b0001000, 1'b0, "jmp_opaddr");
        mem_rdy = 1'b0;
        cyc(7'b0000000, 1'b0, "jmp_opfetch");
        cyc(7'b0000010, 1'b0, "jmp_alu");
        cyc(7'b0001010, 1'b1, "jmp_store");
        chk("jmp_cnt_b", 32'(ib.retired_cnt), 32'd0);

        // STO with one write wait state: fifth instruction wraps the 2-bit counter
        fetch_phase(STO);
        cyc(7'b0001000, 1'b0, "sto_opaddr");
        cyc(7'b0000000, 1'b0, "sto_opfetch");
        cyc(7'b0000000, 1'b0, "sto_alu");
        mem_rdy = 1'b0;
        cyc(7'b0000001, 1'b0, "sto_wait");
        mem_rdy = 1'b1;
        cyc(7'b0000001, 1'b1, "sto_store");
        chk("wrap_cnt_a", 32'(ia.retired_cnt), 32'd5);
        chk("wrap_cnt_b", 32'(ib.retired_cnt), 32'd1);

        // STO stalled in STORE, reset aborts the write
        fetch_phase(STO);
        cyc(7'b0001000, 1'b0, "sto2_opaddr");
        cyc(7'b0000000, 1'b0, "sto2_opfetch");
        cyc(7'b0000000, 1'b0, "sto2_alu");
        mem_rdy = 1'b0;
        cyc(7'b0000001, 1'b0, "sto2_wait0");
        rst_ = 1'b0;
        cyc(7'b0000001, 1'b0, "sto2_wait1");
        chk("abort_wr_a", 32'(ia.mem_wr), 32'd0);
        chk("abort_strb_b", 32'(sb), 32'd0);
        chk("abort_cnt_a", 32'(ia.retired_cnt), 32'd0);
        chk("abort_err_b", 32'(ib.bus_err), 32'd0);
        rst_ = 1'b1; mem_rdy = 1'b1;
        cyc(7'b0000000, 1'b0, "post_iaddr");
        cyc(7'b1000000, 1'b0, "post_ifetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/control_ws.md
Name: control_ws

Overview:
Parametrised next-generation sequencer for the accumulator RISC core. It issues the same seven datapath controls through the same eight-phase instruction cycle as the current controller. It adds three things:
- memory wait-state handshake (mem_rdy)
- bus-timeout error trap
- resumable halt state with a retired-instruction counter

It sits between the instruction register/ALU flags and the datapath/memory strobes.

Parameters:
OPCODE_W, 3, opcode width; encodings HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; other codes decode as no-op.
TIMEOUT_CYC, 16, max consecutive wait cycles before bus error; 0 disables timeout.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  input  1  clock, all state on rising edge
rst_  input  1  synchronous active-low reset
opcode  input  OPCODE_W  current instruction opcode from IR
zero  input  1  accumulator-zero flag
mem_rdy  input  1  memory completes current read/write this cycle
resume  input  1  leave HALTED state
mem_rd  output  1  memory read strobe
load_ir  output  1  load instruction register
halt  output  1  halt indicator
inc_pc  output  1  increment PC
load_ac  output  1  load accumulator
load_pc  output  1  load PC
mem_wr  output  1  memory write strobe
bus_err  output  1  sticky timeout error
instr_done  output  1  one-cycle pulse per retired instruction
retired_cnt  output  CNT_W  retired-instruction count, wraps

Behaviour:
- Reset (rst_=0 at edge) forces the following; reset mid-wait or mid-halt aborts immediately:
  - state=INST_ADDR
  - wait counter, retired_cnt, bus_err all 0
  - all strobes 0 while in INST_ADDR
- States: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED, BUS_ERR.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Strobe decode is combinational from state and opcode (Moore plus opcode):
  - INST_ADDR: none.
  - INST_FETCH: mem_rd.
  - INST_LOAD, IDLE: mem_rd, load_ir.
  - OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(SKZ&zero), load_pc=JMP.
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=JMP, load_pc=JMP, mem_wr=STO.
  - HALTED: halt=1 only.
  - BUS_ERR: all strobes 0.
- Transitions:
  - INST_ADDR→INST_FETCH.
  - INST_FETCH→INST_LOAD only when mem_rdy=1, else stay.
  - INST_LOAD→IDLE→OP_ADDR.
  - OP_ADDR→HALTED if HLT, else OP_FETCH.
  - OP_FETCH→ALU_OP when !ALUOP or mem_rdy=1, else stay.
  - ALU_OP→STORE.
  - STORE→INST_ADDR when opcode!=STO or mem_rdy=1, else stay.
  - HALTED→INST_ADDR when resume=1.
  - BUS_ERR: stays until reset.
- Strobes are held constant for every stall cycle.
- Zero-wait instruction takes 8 cycles.
- Wait counter:
  - Clears on entering any wait-capable state and on any cycle not stalled.
  - Increments each stalled cycle.
  - If TIMEOUT_CYC>0 and a stall occurs with counter==TIMEOUT_CYC-1, next state=BUS_ERR and bus_err=1 (sticky).
  - mem_rdy=1 on that same cycle wins: normal transition, no error.
- Retirement:
  - Occurs on the STORE→INST_ADDR transition, or on the OP_ADDR→HALTED transition.
  - instr_done=1 during that cycle (combinational).
  - retired_cnt increments at that edge, modulo 2^CNT_W.
- resume outside HALTED is ignored. resume=1 at the OP_ADDR edge does not skip HALTED (minimum one HALTED cycle).
- Unknown opcodes: walk all phases with only the fetch/inc_pc strobes; retire normally.

Test Plan:
1. ADD, mem_rdy=1 constantly:
   - 8 cycles INST_ADDR..STORE.
   - mem_rd pattern 0,1,1,1,0,1,1,1.
   - load_ac=1 in ALU_OP and STORE.
   - instr_done pulses in STORE; retired_cnt 0→1.
2. LDA, mem_rdy=0 for 3 cycles in OP_FETCH, TIMEOUT_CYC=16:
   - OP_FETCH lasts 4 cycles with mem_rd=1 held.
   - Instruction takes 11 cycles; no bus_err.
3. TIMEOUT_CYC=4, mem_rdy stuck 0 from INST_FETCH:
   - bus_err=1 after 4 INST_FETCH cycles; all strobes 0 thereafter.
   - Raising mem_rdy does not recover; rst_=0 for one edge clears bus_err and restarts at INST_ADDR.
4. HLT:
   - halt=1 in OP_ADDR and HALTED; retired_cnt +1.
   - resume held 0 for 5 cycles keeps HALTED; resume=1 → INST_ADDR next edge.
5. SKZ with zero=1: inc_pc=1 in ALU_OP. zero=0: inc_pc=0. JMP: load_pc=1 and inc_pc=1 in STORE.
6. STO stalled in STORE (mem_rdy=0), rst_=0 asserted:
   - mem_wr=0 the cycle after the reset edge; state INST_ADDR.
   - With CNT_W=2, 5 instructions give retired_cnt=1 (wrap).
